memory_req_master: RTL
======================

// Module: memory_req_master
// PURPOSE
//  Initiator side of the 8 x 64-bit register-file memory port (D_IN/ADDR/R_ENABLE/W_ENABLE/D_OUT).
//  Accepts single read/write requests from a client over a valid/ready handshake.
//  Sequences the memory enables and returns one response per request over a second valid/ready channel.
//  Sits between datapath/control logic and the memory so that no client ever drives the enables directly.
// PARAMETERS
//  DATA_W   64  data width of request, response and memory port
//  ADDR_W   3   address width; memory depth = 2**ADDR_W
//  RD_LAT   1   edges from M_R_ENABLE sampled high until M_D_OUT valid; legal 1..3
// PORTS
//  CLK          in   1       rising-edge clock
//  RESET        in   1       synchronous, active-low reset
//  REQ_VALID    in   1       client request valid
//  REQ_READY    out  1       block can accept request (IDLE only)
//  REQ_WRITE    in   1       1=write, 0=read
//  REQ_CLEAR    in   1       clear-all request (CLEAR_ALL_EN only)
//  REQ_ADDR     in   ADDR_W  target address
//  REQ_DATA     in   DATA_W  write data
//  RSP_VALID    out  1       response valid
//  RSP_READY    in   1       client accepts response
//  RSP_WRITE    out  1       1=write/clear completion, 0=read data
//  RSP_DATA     out  DATA_W  read data; 0 for writes/clears
//  M_D_IN       out  DATA_W  memory write data
//  M_ADDR       out  ADDR_W  memory address
//  M_R_ENABLE   out  1       memory read enable
//  M_W_ENABLE   out  1       memory write enable
//  M_D_OUT      in   DATA_W  memory read data
// BEHAVIOUR
//  Reset (RESET=0 at edge): state IDLE; all registered outputs 0; REQ_READY=0 while RESET=0.
//  Reset mid-operation: aborts at that edge; enables 0, RSP_VALID 0, pending response discarded.
//  States: IDLE, WR, RD, RWAIT, RESP, CLR.
//  IDLE: REQ_READY=1. Accept on REQ_VALID&REQ_READY at edge T; latch op/addr/data.
//   write -> WR; read -> RD; clear -> CLR.
//  WR (cycle T+1): M_W_ENABLE=1, M_ADDR/M_D_IN = latched values, exactly one cycle -> RESP.
//  RD (cycle T+1): M_R_ENABLE=1, M_ADDR = latched, exactly one cycle -> RWAIT.
//  RWAIT: RD_LAT cycles (counter); capture M_D_OUT into RSP_DATA on last RWAIT edge -> RESP.
//  RESP: RSP_VALID=1; RSP_DATA/RSP_WRITE stable until RSP_READY=1 at edge -> IDLE.
//  Latency accept-edge to RSP_VALID: write 2 cycles, read 2+RD_LAT cycles.
//   With RSP_READY held 1, RESP lasts one cycle.
//  M_R_ENABLE and M_W_ENABLE are never 1 in the same cycle; both 0 outside WR/RD/CLR.
//  M_ADDR/M_D_IN hold last driven values when enables are 0.
//  One outstanding request max; next REQ_READY is the cycle after the response handshake.
//  REQ_* sampled only on accept; changes at other times are ignored.
// CONFIGURATION
//  Macro CLEAR_ALL_EN defined:
//   REQ_CLEAR=1 at accept wins over REQ_WRITE.
//   CLR: 2**ADDR_W consecutive cycles, M_W_ENABLE=1, M_D_IN=0, M_ADDR = 0,1,...,max.
//   After max address -> RESP with RSP_WRITE=1; the address counter does not wrap.
//  Macro undefined: REQ_CLEAR ignored; CLR state and counter not built.
// TESTING
//  1 write 64'h1 to addr 0 -> M_W_ENABLE one cycle at T+1, M_ADDR=0, M_D_IN=1.
//    Also RSP_VALID at T+2 with RSP_WRITE=1, RSP_DATA=0.
//  2 read addr 0 after test 1 (memory model, RD_LAT=1) -> M_R_ENABLE one cycle at T+1.
//    Also RSP_VALID at T+3 with RSP_DATA=64'h1, RSP_WRITE=0.
//  3 read with RSP_READY=0 for 5 cycles -> RSP_VALID/RSP_DATA stable, REQ_READY=0.
//    IDLE on the RSP_READY edge.
//  4 RESET=0 during RWAIT -> next edge: enables 0, RSP_VALID 0, REQ_READY 0.
//    After release, read returns fresh data.
//  5 REQ_VALID=1 continuously, alternating write 64'h2 / read, addr 5, RSP_READY=1.
//    Never R&W enable in the same cycle; each read returns 64'h2.
//  6 (CLEAR_ALL_EN) write 64'hA5 to addr 7, clear, read addr 7.
//    8 write cycles addr 0..7 with D_IN=0; read returns 0.

Source files
------------

// File: rtl/memory_req_master.sv
// memory_req_master: valid/ready request/response front end sequencing the register-file memory enables
// Optional clear-all sweep built when CLEAR_ALL_EN is defined.
module memory_req_master #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 3,
  parameter int RD_LAT = 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic              REQ_WRITE,
  input  logic              REQ_CLEAR,
  input  logic [ADDR_W-1:0] REQ_ADDR,
  input  logic [DATA_W-1:0] REQ_DATA,
  output logic              RSP_VALID,
  input  logic              RSP_READY,
  output logic              RSP_WRITE,
  output logic [DATA_W-1:0] RSP_DATA,
  output logic [DATA_W-1:0] M_D_IN,
  output logic [ADDR_W-1:0] M_ADDR,
  output logic              M_R_ENABLE,
  output logic              M_W_ENABLE,
  input  logic [DATA_W-1:0] M_D_OUT
);
`ifdef CLEAR_ALL_EN
  typedef enum logic [2:0] {IDLE, WR, RD, RWAIT, RESP, CLR} state_t;
`else
  typedef enum logic [2:0] {IDLE, WR, RD, RWAIT, RESP} state_t;
  logic unused_clear;
  assign unused_clear = REQ_CLEAR;
`endif
  localparam logic [1:0] LAT_INIT = 2'(RD_LAT - 1);
  state_t state_q, state_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [DATA_W-1:0] m_d_in_q, m_d_in_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic rsp_write_q, rsp_write_d;
  logic [1:0] lat_cnt_q, lat_cnt_d;
  logic accept;
  assign REQ_READY  = RESET && state_q == IDLE;
  assign accept     = REQ_VALID && REQ_READY;
  assign RSP_VALID  = state_q == RESP;
  assign RSP_WRITE  = rsp_write_q;
  assign RSP_DATA   = rsp_data_q;
  assign M_ADDR     = m_addr_q;
  assign M_D_IN     = m_d_in_q;
  assign M_R_ENABLE = state_q == RD;
`ifdef CLEAR_ALL_EN
  assign M_W_ENABLE = state_q == WR || state_q == CLR;
`else
  assign M_W_ENABLE = state_q == WR;
`endif
  always_comb begin
    state_d     = state_q;
    m_addr_d    = m_addr_q;
    m_d_in_d    = m_d_in_q;
    rsp_data_d  = rsp_data_q;
    rsp_write_d = rsp_write_q;
    lat_cnt_d   = lat_cnt_q;
    case (state_q)
      IDLE: if (accept) begin
        m_addr_d    = REQ_ADDR;
        m_d_in_d    = REQ_WRITE ? REQ_DATA : m_d_in_q;
        rsp_data_d  = '0;
        rsp_write_d = REQ_WRITE;
        state_d     = REQ_WRITE ? WR : RD;
`ifdef CLEAR_ALL_EN
        if (REQ_CLEAR) begin
          m_addr_d    = '0;
          m_d_in_d    = '0;
          rsp_write_d = 1'b1;
          state_d     = CLR;
        end
`endif
      end
      WR: state_d = RESP;
      RD: begin
        lat_cnt_d = LAT_INIT;
        state_d   = RWAIT;
      end
      RWAIT: begin
        lat_cnt_d  = lat_cnt_q == 2'd0 ? lat_cnt_q : lat_cnt_q - 2'd1;
        rsp_data_d = lat_cnt_q == 2'd0 ? M_D_OUT : rsp_data_q;
        state_d    = lat_cnt_q == 2'd0 ? RESP : RWAIT;
      end
      RESP: state_d = RSP_READY ? IDLE : RESP;
`ifdef CLEAR_ALL_EN
      // the sweep stops on the top address instead of wrapping
      CLR: begin
        m_addr_d = m_addr_q == '1 ? m_addr_q : m_addr_q + 1'b1;
        state_d  = m_addr_q == '1 ? RESP : CLR;
      end
`endif
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q     <= IDLE;
      m_addr_q    <= '0;
      m_d_in_q    <= '0;
      rsp_data_q  <= '0;
      rsp_write_q <= 1'b0;
      lat_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      m_addr_q    <= m_addr_d;
      m_d_in_q    <= m_d_in_d;
      rsp_data_q  <= rsp_data_d;
      rsp_write_q <= rsp_write_d;
      lat_cnt_q   <= lat_cnt_d;
    end
  end
endmodule
